// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI responder.
package mcp3008_pkg;

  localparam int CMD_BITS  = 4;
  localparam int DATA_BITS = 10;
  localparam int NUM_CH    = 8;
  localparam int ADC_W     = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    SAMPLE,
    NULL,
    DATA,
    DONE
  } state_t;

  // Pseudo-differential result: IN+ minus IN-, clamped at zero when IN- is larger.
  function automatic logic [ADC_W-1:0] diff_clamp(input logic [ADC_W-1:0] in_p,
                                                  input logic [ADC_W-1:0] in_n);
    logic [ADC_W:0] d;
    d = {1'b0, in_p} - {1'b0, in_n};
    return d[ADC_W] ? '0 : d[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for the asynchronous SPI pins plus edge detection
// on the synchronised sclk and cs_n.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic cs_n_in,
  input  logic mosi_in,
  output logic sclk,
  output logic cs_n,
  output logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] cs_q, cs_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  // Shift each pin one stage deeper per clock; remember last synchronised level.
  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk_in};
    cs_d        = {cs_q[SYNC_STAGES-2:0], cs_n_in};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi_in};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
    cs_prev_d   = cs_q[SYNC_STAGES-1];
  end

  // Synchroniser registers; cs_n idles high and sclk low out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk      = sclk_q[SYNC_STAGES-1];
  assign cs_n      = cs_q[SYNC_STAGES-1];
  assign mosi      = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk & ~sclk_prev_q;
  assign sclk_fall = ~sclk & sclk_prev_q;
  assign cs_fall   = ~cs_n & cs_prev_q;
  assign cs_rise   = cs_n & ~cs_prev_q;

endmodule

// File: rtl/mcp3008_spi_responder.sv
// MCP3008 emulator: decodes start/SGL/D2..D0 from MOSI and returns the null
// bit followed by a 10-bit value taken from a parallel-loaded channel bank.
module mcp3008_spi_responder
  import mcp3008_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [ADC_W-1:0] RESET_VALUE = 10'h200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [ADC_W-1:0] wr_data,
  output logic             conv_valid,
  output logic [2:0]       conv_ch,
  output logic             conv_sgl,
  output logic [ADC_W-1:0] conv_data,
  output logic             abort
);

  localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

  logic sclk_s, cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic unused_sclk_level;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (spi_sclk),
    .cs_n_in   (spi_cs_n),
    .mosi_in   (spi_mosi),
    .sclk      (sclk_s),
    .cs_n      (cs_n_s),
    .mosi      (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  // Only the edge pulses drive the protocol; the raw sclk level is not needed.
  assign unused_sclk_level = sclk_s;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;          // {SGL, D2, D1, D0}
  logic [ADC_W-1:0] shift_q, shift_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             conv_valid_q, conv_valid_d;
  logic [2:0]       conv_ch_q, conv_ch_d;
  logic             conv_sgl_q, conv_sgl_d;
  logic [ADC_W-1:0] conv_data_q, conv_data_d;
  logic             abort_q, abort_d;
  logic [ADC_W-1:0] bank_q [NUM_CH];
  logic [ADC_W-1:0] bank_d [NUM_CH];
  logic [ADC_W-1:0] in_p, in_n, result;

  // Bank write port: a write lands on the next edge, after any same-cycle read.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) bank_d[wr_addr] = wr_data;
  end

  // Result for the captured command: direct channel, or clamped pair difference.
  always_comb begin
    in_p   = bank_q[cmd_q[2:0]];
    in_n   = bank_q[{cmd_q[2:1], ~cmd_q[0]}];
    result = cmd_q[3] ? in_p : diff_clamp(in_p, in_n);
  end

  // Protocol FSM: next state and registered outputs; deselect overrides everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    shift_d      = shift_q;
    miso_d       = miso_q;
    oe_d         = oe_q;
    conv_valid_d = 1'b0;
    conv_ch_d    = conv_ch_q;
    conv_sgl_d   = conv_sgl_q;
    conv_data_d  = conv_data_q;
    abort_d      = 1'b0;
    if (cs_n_s) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      // Only a deselect after the command but before B0 went out is an abort.
      abort_d = cs_rise && (state_q inside {SAMPLE, NULL, DATA});
    end else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = WAIT_START;
        WAIT_START: begin
          if (sclk_rise && mosi_s) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d = {cmd_q[2:0], mosi_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CMD_LAST) state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          if (sclk_fall) begin
            conv_valid_d = 1'b1;
            conv_ch_d    = cmd_q[2:0];
            conv_sgl_d   = cmd_q[3];
            conv_data_d  = result;
            shift_d      = result;
            state_d      = NULL;
          end
        end
        NULL: begin
          // The rising edge in between is skipped simply by waiting for a fall.
          if (sclk_fall) begin
            miso_d  = 1'b0;
            oe_d    = 1'b1;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            miso_d  = shift_q[ADC_W-1];
            shift_d = {shift_q[ADC_W-2:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == DATA_LAST) state_d = DONE;
          end
        end
        DONE: if (sclk_fall) miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, output and bank registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      shift_q      <= '0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_ch_q    <= '0;
      conv_sgl_q   <= 1'b0;
      conv_data_q  <= '0;
      abort_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= RESET_VALUE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      shift_q      <= shift_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      conv_valid_q <= conv_valid_d;
      conv_ch_q    <= conv_ch_d;
      conv_sgl_q   <= conv_sgl_d;
      conv_data_q  <= conv_data_d;
      abort_q      <= abort_d;
      bank_q       <= bank_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign conv_valid  = conv_valid_q;
  assign conv_ch     = conv_ch_q;
  assign conv_sgl    = conv_sgl_q;
  assign conv_data   = conv_data_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Scoreboard bench for the MCP3008 responder: a bit-banged SPI mode-0 master,
// a plain-arithmetic channel model, and a conv_valid/abort monitor.
module tb_mcp3008_spi_responder;

  logic       clk = 1'b0;
  logic       rst, spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
  logic       wr_en, conv_valid, conv_sgl, abort;
  logic [2:0] wr_addr, conv_ch;
  logic [9:0] wr_data, conv_data;

  int checks = 0, failures = 0, abort_cnt = 0, exp_aborts = 0;
  int bank_m [8];
  logic [13:0] exp_q [$];          // {ch, sgl, data}
  logic [13:0] mon_a, mon_e;

  always #5 clk = ~clk;

  mcp3008_spi_responder #(.SYNC_STAGES(2), .RESET_VALUE(10'h200)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .conv_valid(conv_valid), .conv_ch(conv_ch), .conv_sgl(conv_sgl),
    .conv_data(conv_data), .abort(abort)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every result latch is popped against the scoreboard.
  always @(negedge clk) begin
    if (conv_valid) begin
      mon_a = {conv_ch, conv_sgl, conv_data};
      if (exp_q.size() == 0) begin
        check("conv_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("conv_result", 64'(mon_a), 64'(mon_e));
      end
    end
    if (abort) abort_cnt++;
  end

  // Reference: single-ended reads the channel; differential subtracts the
  // pair partner and clamps negative results to zero.
  function automatic int model_conv(input bit sgl, input int ch);
    int p, ip, im;
    if (sgl) return bank_m[ch];
    p  = ch / 2;
    ip = bank_m[2 * p + ch % 2];
    im = bank_m[2 * p + 1 - ch % 2];
    return (ip >= im) ? ip - im : 0;
  endfunction

  task automatic bank_write(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_data = d[9:0];
    @(negedge clk);
    wr_en = 1'b0;
    bank_m[a] = d;
  endtask

  // Half an SCLK period (4 clk); optionally strobe a bank write so that it
  // coincides with the result latch of a falling edge issued just before.
  task automatic half_wait(input bit do_wr, input int a, input int d);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (do_wr && i == 2) begin wr_en = 1'b1; wr_addr = a[2:0]; wr_data = d[9:0]; end
      if (do_wr && i == 3) wr_en = 1'b0;
    end
  endtask

  // Mode-0 master: nclk clocks, MOSI = lead extra zeros then 0x01, cmd nibble.
  task automatic spi_xfer(input int lead, input bit sgl, input int ch, input int nclk,
                          input bit raise_cs, input int wr_fall, input int wr_a, input int wr_d,
                          output logic [63:0] miso_v, output logic [63:0] oe_v);
    int s;
    logic [63:0] mosi_v;
    s = 8 + lead;
    mosi_v = '0;
    mosi_v[s] = 1'b1; mosi_v[s+1] = sgl;
    mosi_v[s+2] = ch[2]; mosi_v[s+3] = ch[1]; mosi_v[s+4] = ch[0];
    miso_v = '0; oe_v = '0;
    @(negedge clk);
    spi_cs_n = 1'b0; spi_mosi = mosi_v[1];
    half_wait(1'b0, 0, 0);
    for (int k = 1; k <= nclk; k++) begin
      spi_sclk = 1'b1;
      miso_v[k] = spi_miso; oe_v[k] = spi_miso_oe;
      half_wait(1'b0, 0, 0);
      spi_sclk = 1'b0; spi_mosi = mosi_v[k+1];
      half_wait(k == wr_fall, wr_a, wr_d);
    end
    if (raise_cs) begin
      spi_cs_n = 1'b1;
      half_wait(1'b0, 0, 0);
      check("oe_after_cs", 64'(spi_miso_oe), 64'd0);
      for (int i = 0; i < 6; i++) @(negedge clk);
    end
  endtask

  // Expected MISO picture: null at s+6, B9..B0 at s+7..s+16, driven from s+6 on.
  task automatic check_stream(input string tag, input int lead, input int nclk, input int data,
                              input logic [63:0] miso_v, input logic [63:0] oe_v);
    logic [63:0] em, eo;
    int s;
    s = 8 + lead; em = '0; eo = '0;
    for (int k = 1; k <= nclk; k++) begin
      if (k >= s + 6) eo[k] = 1'b1;
      if (k >= s + 7 && k <= s + 16) em[k] = data[9 - (k - s - 7)];
    end
    check({tag, "_oe"}, oe_v, eo);
    check({tag, "_miso"}, miso_v & oe_v, em);
  endtask

  task automatic do_read(input string tag, input int lead, input bit sgl, input int ch,
                         input int wr_fall, input int wr_a, input int wr_d,
                         output logic [63:0] miso_v);
    int exp;
    logic [63:0] oe_v;
    exp = model_conv(sgl, ch);
    exp_q.push_back({3'(ch), sgl, 10'(exp)});
    spi_xfer(lead, sgl, ch, 24 + lead, 1'b1, wr_fall, wr_a, wr_d, miso_v, oe_v);
    check_stream(tag, lead, 24 + lead, exp, miso_v, oe_v);
    check({tag, "_aborts"}, 64'(abort_cnt), 64'(exp_aborts));
    $display("xfer %s sgl=%0d ch=%0d lead=%0d expected=%03h", tag, sgl, ch, lead, exp);
  endtask

  logic [63:0] mv, ov;
  logic [7:0]  byte3;
  int          r_ch, r_lead, n_wr;
  bit          r_sgl;

  initial begin
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) bank_m[i] = 'h200;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({spi_miso, spi_miso_oe, conv_valid, conv_ch, conv_sgl, conv_data, abort}), 64'd0);

    // Single-ended read of channel 2.
    bank_write(2, 'h2A5);
    do_read("single", 0, 1'b1, 2, 0, 0, 0, mv);
    byte3 = '0;
    for (int k = 17; k <= 24; k++) byte3 = {byte3[6:0], mv[k]};
    check("byte3", 64'(byte3), 64'h A5);
    check("byte2_low", 64'({mv[14], mv[15], mv[16]}), 64'b010);

    // Differential pair 0/1: positive result and clamp.
    bank_write(0, 'h300);
    bank_write(1, 'h100);
    do_read("diff_pos", 0, 1'b0, 0, 0, 0, 0, mv);
    do_read("diff_clamp", 0, 1'b0, 1, 0, 0, 0, mv);

    // Five extra leading zeros.
    bank_write(7, 'h3FF);
    do_read("lead5", 5, 1'b1, 7, 0, 0, 0, mv);

    // Deselect right after B9 went out.
    bank_write(4, 'h1C3);
    exp_q.push_back({3'd4, 1'b1, 10'h1C3});
    spi_xfer(0, 1'b1, 4, 14, 1'b1, 0, 0, 0, mv, ov);
    exp_aborts++;
    check("abort_count", 64'(abort_cnt), 64'(exp_aborts));
    check_stream("abort", 0, 14, 'h1C3, mv, ov);
    $display("xfer abort ch=4 after B9 aborts=%0d", abort_cnt);
    do_read("after_abort", 0, 1'b1, 4, 0, 0, 0, mv);

    // Write to bank[3] exactly on the latch of a ch=3 read.
    bank_write(3, 'h155);
    do_read("collide", 0, 1'b1, 3, 12, 3, 'h2AA, mv);
    bank_m[3] = 'h2AA;
    do_read("collide_next", 0, 1'b1, 3, 0, 0, 0, mv);

    // Randomised reads against the model.
    for (int t = 0; t < 20; t++) begin
      n_wr = $urandom_range(0, 2);
      for (int w = 0; w < n_wr; w++) bank_write($urandom_range(0, 7), $urandom_range(0, 1023));
      r_sgl = 1'($urandom_range(0, 1));
      r_ch = $urandom_range(0, 7);
      r_lead = $urandom_range(0, 3);
      do_read("random", r_lead, r_sgl, r_ch, 0, 0, 0, mv);
    end

    // Reset in the middle of DATA.
    bank_write(6, 'h0F0);
    exp_q.push_back({3'd6, 1'b1, 10'h0F0});
    spi_xfer(0, 1'b1, 6, 18, 1'b0, 0, 0, 0, mv, ov);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_oe", 64'(spi_miso_oe), 64'd0);
    check("rst_mid_conv", 64'({conv_ch, conv_sgl, conv_data}), 64'd0);
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_abort", 64'(abort_cnt), 64'(exp_aborts));
    $display("xfer reset_mid_data aborts=%0d", abort_cnt);
    for (int i = 0; i < 8; i++) bank_m[i] = 'h200;
    do_read("post_rst_single", 0, 1'b1, 5, 0, 0, 0, mv);
    do_read("post_rst_diff", 0, 1'b0, 4, 0, 0, 0, mv);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcp3008_spi_responder.md
Name: mcp3008_spi_responder

Overview:
- SPI-mode-0 responder that emulates an MCP3008 8-channel 10-bit ADC on the sensor SPI bus. It is the device end of the link our SPI master drives.
- It holds an 8-entry register bank of channel values, loaded over a parallel write port. It decodes start, SGL/DIFF and D2..D0 from MOSI, then returns the null bit plus B9..B0 on MISO.
- Uses: hardware-in-the-loop sensor emulation, and loopback self-test of the classifier's SPI master.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the spi_sclk, spi_cs_n and spi_mosi synchronisers (minimum 2).
- RESET_VALUE, 10'h200, value loaded into every bank entry at reset.

Ports:
- clk  input  1  system clock; must satisfy f_clk >= 8 x f_sclk
- rst  input  1  synchronous reset, active-high
- spi_sclk  input  1  SPI clock from master (asynchronous)
- spi_cs_n  input  1  chip select, active-low (asynchronous)
- spi_mosi  input  1  master data in (asynchronous)
- spi_miso  output  1  responder data out
- spi_miso_oe  output  1  MISO drive enable; 0 = high-Z
- wr_en  input  1  bank write strobe
- wr_addr  input  3  bank entry index
- wr_data  input  10  bank write value
- conv_valid  output  1  one-cycle pulse when a result is latched
- conv_ch  output  3  D2..D0 of the latched command
- conv_sgl  output  1  SGL/DIFF bit of the latched command
- conv_data  output  10  value latched for shifting out
- abort  output  1  one-cycle pulse when CS deasserts before B0 has been driven

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE and every bank entry to RESET_VALUE.
  - spi_miso=0, spi_miso_oe=0, conv_valid=0, conv_ch=0, conv_sgl=0, conv_data=0, abort=0.
  - Synchroniser and edge-detect registers clear to cs_n=1, sclk=0.
  - Reset mid-transfer does not pulse abort.
- Synchronisation and edges:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Rise and fall of sclk are detected on the synchronised signals.
  - The effect of an SPI edge appears SYNC_STAGES+1 clk cycles later.
- Bank writes: take effect on the next clk edge. A write in the same cycle as the result latch is not visible in that result.
- Synchronised cs_n=1 forces IDLE from any state on the same cycle and sets spi_miso_oe=0. It pulses abort if the state was SAMPLE, NULL or DATA.
- IDLE: cs_n falls -> WAIT_START.
- WAIT_START: a rising edge with mosi=1 -> CMD. Leading zeros are ignored without limit.
- CMD: capture 4 bits MSB-first on rising edges, in the order SGL, D2, D1, D0. After D0 -> SAMPLE.
- SAMPLE:
  - On the first falling edge, latch conv_data, conv_ch and conv_sgl, and pulse conv_valid.
  - The next rising edge is ignored. On the following falling edge, drive spi_miso=0 (null bit), set spi_miso_oe=1, and go to DATA.
- Result arithmetic:
  - SGL=1: conv_data = bank[ch].
  - SGL=0 (pseudo-differential): pair p = ch[2:1]. IN+ = bank[2p+ch[0]], IN- = bank[2p+!ch[0]].
  - conv_data = IN+ - IN- when IN+ >= IN-; otherwise 0 (11-bit compare, clamp at zero).
- DATA: 10 falling edges drive B9..B0 MSB-first, then -> DONE.
- DONE: spi_miso=0 and spi_miso_oe stays 1 on further falling edges. No LSB-first repeat. Leave only on cs_n=1.
- A 24-clock transfer of 0x01, {SGL,D2,D1,D0,xxxx}, 0x00 therefore returns byte2[2:0] = {0, B9, B8} and byte3 = B7..B0. Byte2[7:3] are undriven.
- spi_miso changes only in response to falling edges; the master samples it on rising edges.

Decomposition:
- Package mcp3008_pkg holds:
  - state enum {IDLE, WAIT_START, CMD, SAMPLE, NULL, DATA, DONE}
  - constants CMD_BITS=4, DATA_BITS=10, NUM_CH=8, ADC_W=10
- One sub-module, spi_sync_edge: SYNC_STAGES synchroniser for sclk, cs_n and mosi. Outputs sync levels plus sclk_rise, sclk_fall, cs_fall and cs_rise pulses.

Test Plan:
- Single-ended read: bank[2]=10'h2A5; send 0x01, 0xA0, 0x00 -> conv_valid once with conv_ch=2, conv_sgl=1, conv_data=10'h2A5; byte2[2:0]=3'b010; byte3=8'hA5; MISO high-Z during byte1 and byte2[7:3].
- Differential read: bank[0]=10'h300, bank[1]=10'h100; cmd SGL=0, ch=000 -> conv_data=10'h200; cmd ch=001 -> conv_data=10'h000 (clamp).
- Leading zeros: 5 extra zero bits before the start bit, bank[7]=10'h3FF, ch=7 -> returns 10'h3FF, with the bit alignment shifted by 5.
- Abort: cs_n rises after B9 -> abort pulse, spi_miso_oe=0 within SYNC_STAGES+2 clk; next full transfer is correct. cs_n rising in DONE -> no abort.
- Write collision: wr_en to bank[3] in the same cycle as the result latch for ch=3 -> old value returned; the following transfer returns the new value.
- Reset mid-DATA: rst=1 for 1 clk -> spi_miso_oe=0, bank = 10'h200 everywhere, no abort pulse.
